// File: rtl/posit_mult_arbiter.sv
// rtl/posit_mult_arbiter.sv - round-robin arbiter sharing one posit multiplier; op_count built only with POSIT_MULT_ARB_STATS_EN
module Mult_Arithmetic #(
    parameter int N  = 8,
    parameter int ES = 4
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N-1:0] out
);
    localparam int SW = 16;
    localparam int RW = $clog2(N) + 1;
    localparam int PW = 2 * N + 2;
    localparam int FW = 2 * N + 1;
    localparam int XW = N + 1 + ES + FW;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [SW-1:0] ONE = 1;
    localparam logic signed [SW-1:0] LIM = SW'(N - 1);
    localparam logic signed [SW-1:0] NW  = SW'(N);

    // Returns {scale, left-aligned fraction} of |x|; missing exponent bits read as zero.
    function automatic logic [SW+N-1:0] decode(input logic [N-1:0] x);
        logic [N-1:0]         ax;
        logic [RW-1:0]        m;
        logic                 done;
        logic [N+ES-1:0]      rem;
        logic signed [SW-1:0] k;
        ax   = x[N-1] ? -x : x;
        m    = '0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && (ax[i] == ax[N-2])) m = m + RW'(1);
            else                              done = 1'b1;
        end
        k   = ax[N-2] ? $signed(SW'(m)) - ONE : -$signed(SW'(m));
        rem = {ax, {ES{1'b0}}} << (m + RW'(2));
        return {(k <<< ES) + $signed(SW'(rem[N+ES-1 -: ES])), rem[N-1:0]};
    endfunction

    logic [SW+N-1:0]      d1, d2;
    logic signed [SW-1:0] scale, k, run;
    logic [PW-1:0]        prod;
    logic [FW-1:0]        frac;
    logic [XW-1:0]        x, xs;
    logic [N-2:0]         body;
    logic                 guard, sticky, kpos, neg;
    logic [N-1:0]         mag;

    // Decode, multiply mantissas, re-encode with round-to-nearest-even and posit saturation.
    always_comb begin
        d1    = decode(in1);
        d2    = decode(in2);
        neg   = in1[N-1] ^ in2[N-1];
        prod  = PW'({1'b1, d1[N-1:0]}) * PW'({1'b1, d2[N-1:0]});
        scale = $signed(d1[SW+N-1:N]) + $signed(d2[SW+N-1:N]);
        if (prod[PW-1]) begin
            scale = scale + ONE;
            frac  = prod[PW-2:0];
        end else begin
            frac  = {prod[PW-3:0], 1'b0};
        end
        k      = scale >>> ES;
        kpos   = !k[SW-1];
        run    = kpos ? k + ONE : -k;
        x      = {{N{kpos}}, !kpos, scale[ES-1:0], frac};
        xs     = x << $unsigned(NW - run);
        body   = xs[XW-1 -: N-1];
        guard  = xs[XW-N];
        sticky = |xs[XW-N-1:0];
        if (run >= LIM)
            body = kpos ? '1 : (N-1)'(1);
        else if (guard && (sticky || body[0]) && !(&body))
            body = body + (N-1)'(1);
        mag = {1'b0, body};
        out = neg ? -mag : mag;
        if (in1 == NAR || in2 == NAR)
            out = NAR;
        else if (in1 == '0 || in2 == '0)
            out = '0;
    end
endmodule

module posit_mult_arbiter #(
    parameter int N    = 8,
    parameter int ES   = 4,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              busy,
    output logic [15:0]       op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, grant_id, id_q;
    logic [IDW:0]   idx;
    logic           grant_hit;
    logic [N-1:0]   op_a, op_b, product;

    Mult_Arithmetic #(.N(N), .ES(ES)) u_mult (
        .in1 (op_a),
        .in2 (op_b),
        .out (product)
    );

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!grant_hit && req_valid[idx[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant_id  = idx[IDW-1:0];
            end
        end
    end

    // Next state and the single-bit grant; grants only from IDLE, never from resp_ready.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (grant_hit) begin
                req_ready[grant_id] = 1'b1;
                state_nxt           = EXEC;
            end
            EXEC: state_nxt = HOLD;
            HOLD: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand capture on grant, result capture in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_hit) begin
                op_a <= req_a[grant_id*N +: N];
                op_b <= req_b[grant_id*N +: N];
                id_q <= grant_id;
                ptr  <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            if (state == EXEC) begin
                resp_data <= product;
                resp_id   <= id_q;
            end
        end
    end

    assign resp_valid = (state == HOLD);
    assign busy       = (state != IDLE);

`ifdef POSIT_MULT_ARB_STATS_EN
    logic [15:0] op_count_q;

    // Saturating count of completed response handshakes.
    always_ff @(posedge clk) begin
        if (reset)
            op_count_q <= '0;
        else if (resp_valid && resp_ready && op_count_q != 16'hFFFF)
            op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'h0000;
`endif
endmodule

// File: tb/tb_posit_mult_arbiter.sv
// tb/tb_posit_mult_arbiter.sv - self-checking bench for posit_mult_arbiter with a posit reference model
module tb_posit_mult_arbiter;
    localparam int N    = 8;
    localparam int ES   = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam logic [N-1:0] NAR    = 8'h80;
    localparam logic [N-1:0] MAXPOS = 8'h7F;
`ifdef POSIT_MULT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int           id;
        logic [N-1:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [N-1:0]      resp_data;
    logic [IDW-1:0]    resp_id;
    logic              busy;
    logic [15:0]       op_count;

    logic [N-1:0] a_arr [NREQ];
    logic [N-1:0] b_arr [NREQ];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ptr_m, cnt_m;
    exp_t exp_q[$];

    posit_mult_arbiter #(.N(N), .ES(ES), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_a[i*N +: N] = a_arr[i];
        assign req_b[i*N +: N] = b_arr[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Posit value = (-1)^neg * 2^scale * mant / 2^fb
    function automatic void ref_decode(input logic [N-1:0] p, output bit neg,
                                       output int scale, output longint mant, output int fb);
        logic [N-1:0] v;
        int i, run, k, e;
        bit r0;
        neg = p[N-1];
        v   = neg ? -p : p;
        r0  = v[N-2];
        run = 0;
        i   = N - 2;
        while (i >= 0) begin
            if (v[i] != r0) break;
            run++;
            i--;
        end
        k = r0 ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
            i--;
        end
        mant = 1;
        fb   = 0;
        while (i >= 0) begin
            mant = mant * 2 + longint'(v[i]);
            fb++;
            i--;
        end
        scale = k * (1 << ES) + e;
    endfunction

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int     sc1, sc2, fb1, fb2, sc, fb, k, e;
        longint m1, m2, m;
        bit     n1, n2, guard, sticky;
        bit     q[$];
        logic [N-1:0] body;
        if (x == NAR || y == NAR) return NAR;
        if (x == '0 || y == '0) return '0;
        ref_decode(x, n1, sc1, m1, fb1);
        ref_decode(y, n2, sc2, m2, fb2);
        m  = m1 * m2;
        fb = fb1 + fb2;
        sc = sc1 + sc2;
        if (m >= (longint'(2) << fb)) begin
            sc++;
            fb++;
        end
        k = sc / (1 << ES);
        if (k * (1 << ES) > sc) k--;
        e = sc - k * (1 << ES);
        if (k >= N - 2) begin
            body = MAXPOS;
        end else if (k <= -(N - 1)) begin
            body = 1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = ES - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
            for (int i = fb - 1; i >= 0; i--) q.push_back(bit'((m >> i) & 1));
            while (q.size() < N) q.push_back(1'b0);
            body = '0;
            for (int i = 0; i < N - 1; i++) body = {body[N-2:0], q[i]};
            guard  = q[N-1];
            sticky = 1'b0;
            for (int i = N; i < q.size(); i++) sticky = sticky | q[i];
            if (guard && (sticky || body[0]) && body != MAXPOS) body = body + 1'b1;
        end
        return (n1 ^ n2) ? -body : body;
    endfunction

    function automatic logic [31:0] exp_count();
        return STATS ? 32'(cnt_m) : 32'd0;
    endfunction

    // One full transaction: grant in IDLE, EXEC, HOLD for 'stall' extra cycles, then handshake.
    task automatic do_op(input logic [NREQ-1:0] mask, input int stall, input int want);
        int g;
        logic [N-1:0] exp_d;
        g = 0;
        for (int j = NREQ - 1; j >= 0; j--)
            if (mask[(ptr_m + j) % NREQ]) g = (ptr_m + j) % NREQ;
        exp_d = (want < 0) ? ref_mul(a_arr[g], b_arr[g]) : N'(want);
        req_valid = mask;
        #1;
        check("grant", 32'(req_ready), 32'(1) << g);
        check("idle_busy", 32'(busy), 0);
        @(posedge clk); #1;
        req_valid = '0;
        ptr_m = (g + 1) % NREQ;
        #1;
        check("exec_busy", 32'(busy), 1);
        check("exec_valid", 32'(resp_valid), 0);
        check("exec_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("resp_valid", 32'(resp_valid), 1);
        check("resp_data", 32'(resp_data), 32'(exp_d));
        check("resp_id", 32'(resp_id), 32'(g));
        for (int s = 0; s < stall; s++) begin
            req_valid = mask;
            #1;
            check("hold_ready", 32'(req_ready), 0);
            check("hold_busy", 32'(busy), 1);
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_data", 32'(resp_data), 32'(exp_d));
            check("hold_id", 32'(resp_id), 32'(g));
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (cnt_m < 65535) cnt_m++;
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(resp_valid), 0);
        check("op_count", 32'(op_count), exp_count());
    endtask

    initial begin
        int n_g, n_r, last_c;
        logic [N-1:0] dir_a [5] = '{8'h40, 8'h42, 8'hC0, 8'h00, 8'h80};
        logic [N-1:0] dir_b [5] = '{8'h40, 8'h42, 8'h40, 8'h42, 8'h40};
        logic [N-1:0] dir_p [5] = '{8'h40, 8'h44, 8'hC0, 8'h00, 8'h80};

        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        ptr_m = 0;
        cnt_m = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(resp_valid), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_data", 32'(resp_data), 0);
        check("rst_id", 32'(resp_id), 0);
        check("rst_count", 32'(op_count), 0);

        // Directed arithmetic; the first is the single request from requester 0.
        for (int i = 0; i < 5; i++) begin
            a_arr[i % NREQ] = dir_a[i];
            b_arr[i % NREQ] = dir_b[i];
            do_op(NREQ'(1) << (i % NREQ), 0, int'(dir_p[i]));
        end
        check("count_after_5", 32'(op_count), STATS ? 32'd5 : 32'd0);

        // Backpressure: ten stalled cycles with requests pending.
        a_arr[1] = N'($urandom);
        b_arr[1] = N'($urandom);
        a_arr[3] = N'($urandom);
        b_arr[3] = N'($urandom);
        do_op(4'b1010, 10, -1);

        // Reset while requester 1 is in EXEC.
        a_arr[1]  = N'($urandom);
        b_arr[1]  = N'($urandom);
        req_valid = 4'b0010;
        #1;
        check("abort_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        check("abort_exec", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr_m = 0;
        cnt_m = 0;
        #1;
        check("abort_valid", 32'(resp_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_count", 32'(op_count), 0);
        @(posedge clk); #1;
        check("abort_no_resp", 32'(resp_valid), 0);

        // Round robin with every requester asserting continuously.
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = N'($urandom);
            b_arr[i] = N'($urandom);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        n_g    = 0;
        n_r    = 0;
        last_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 13) req_valid = '0;
            #1;
            if (req_ready != '0) begin
                check("rr_grant", 32'(req_ready), 32'(1) << ptr_m);
                if (last_c >= 0) check("rr_interval", 32'(c - last_c), 3);
                last_c = c;
                exp_q.push_back('{id: ptr_m, d: ref_mul(a_arr[ptr_m], b_arr[ptr_m])});
                ptr_m = (ptr_m + 1) % NREQ;
                n_g++;
            end
            if (resp_valid) begin
                check("rr_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("rr_id", 32'(resp_id), 32'(exp_q[0].id));
                    check("rr_data", 32'(resp_data), 32'(exp_q[0].d));
                    void'(exp_q.pop_front());
                end
                if (cnt_m < 65535) cnt_m++;
                n_r++;
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        check("rr_grants", 32'(n_g), 5);
        check("rr_resps", 32'(n_r), 5);
        check("rr_count", 32'(op_count), exp_count());

        // Requester 2 after the aborted operation.
        a_arr[2] = N'($urandom);
        b_arr[2] = N'($urandom);
        do_op(4'b0100, 0, -1);

        // Randomized requester subsets, operands and stalls.
        repeat (30) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = N'($urandom);
                b_arr[i] = N'($urandom);
            end
            do_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 3)), -1);
        end

`ifdef POSIT_MULT_ARB_STATS_EN
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        cnt_m = 65535;
        check("sat_forced", 32'(op_count), 32'hFFFF);
        do_op(4'b0001, 0, -1);
        check("sat_hold", 32'(op_count), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
